// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: FSM state encoding and the ALU fun3/fun7 codes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic [2:0] ALU_ADDSUB = 3'b000;
  localparam logic [2:0] ALU_SLL    = 3'b001;
  localparam logic [2:0] ALU_SLT    = 3'b010;
  localparam logic [2:0] ALU_SLTU   = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_SR     = 3'b101;
  localparam logic [2:0] ALU_OR     = 3'b110;
  localparam logic [2:0] ALU_AND    = 3'b111;

  localparam logic [6:0] FUN7_SUB   = 7'h20;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after (last+1) mod NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      grant,
  output logic               any_grant
);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, one op in flight.
// Optional WAIT timeout abort enabled by the ALU_ARB_TIMEOUT_EN macro.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*7-1:0]  req_fun7,
  input  logic [NUM_REQ*3-1:0]  req_fun3,
  input  logic [NUM_REQ*32-1:0] req_rs1,
  input  logic [NUM_REQ*32-1:0] req_rs2,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_res,
  output logic                  resp_zero,
  output logic                  resp_neg,
  output logic                  resp_err,
  output logic                  alu_start,
  output logic [6:0]            alu_fun7,
  output logic [2:0]            alu_fun3,
  output logic [31:0]           alu_rs1,
  output logic [31:0]           alu_rs2,
  input  logic [31:0]           alu_res,
  input  logic                  alu_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 4) && (TIMEOUT >= 1);

  // Elaboration stops on an unsupported configuration.
  if (!CFG_OK) begin : g_cfg_bad
    alu_arbiter_bad_config u_bad_config ();
  end

  arb_state_t    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant;
  logic [IW-1:0] pick;
  logic          any_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req       (req_valid),
    .last      (last_grant),
    .grant     (pick),
    .any_grant (any_grant)
  );

  // Acceptance is combinational in IDLE; held low during reset so every output is 0.
  always_comb begin
    req_ready = '0;
    if (reset_n && state == ARB_IDLE && any_grant) req_ready[pick] = 1'b1;
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant      <= '0;
      alu_start  <= 1'b0;
      alu_fun7   <= '0;
      alu_fun3   <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      resp_valid <= '0;
      resp_res   <= '0;
      resp_zero  <= 1'b0;
      resp_neg   <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      alu_start <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_grant) begin
            grant     <= pick;
            alu_fun7  <= req_fun7[7*pick +: 7];
            alu_fun3  <= req_fun3[3*pick +: 3];
            alu_rs1   <= req_rs1[32*pick +: 32];
            alu_rs2   <= req_rs2[32*pick +: 32];
            alu_start <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          state <= ARB_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ARB_WAIT: begin
          if (alu_done) begin
            resp_res   <= alu_res;
            resp_zero  <= (alu_res == 32'd0);
            resp_neg   <= alu_res[31];
            resp_valid <= NUM_REQ'(1) << grant;
            state      <= ARB_RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          // A done arriving on the last allowed cycle takes the branch above.
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            resp_res   <= '0;
            resp_zero  <= 1'b1;
            resp_neg   <= 1'b0;
            resp_err   <= 1'b1;
            resp_valid <= NUM_REQ'(1) << grant;
            state      <= ARB_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ARB_RESP: begin
          if (resp_ready[grant]) begin
            last_grant <= grant;
            resp_valid <= '0;
            state      <= ARB_IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural add/sub ALU responder.
// Timeout vectors run only when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [NUM_REQ*7-1:0]  req_fun7;
  logic [NUM_REQ*3-1:0]  req_fun3;
  logic [NUM_REQ*32-1:0] req_rs1, req_rs2;
  logic [31:0]           resp_res, alu_rs1, alu_rs2, alu_res;
  logic                  resp_zero, resp_neg, resp_err, alu_start, alu_done;
  logic [6:0]            alu_fun7;
  logic [2:0]            alu_fun3;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fun7(req_fun7), .req_fun3(req_fun3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res(resp_res), .resp_zero(resp_zero), .resp_neg(resp_neg), .resp_err(resp_err),
    .alu_start(alu_start), .alu_fun7(alu_fun7), .alu_fun3(alu_fun3),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_res(alu_res), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int starts = 0;
  int both_ready = 0;
  bit log_en = 1'b0;
  bit alu_en = 1'b1;
  int done_dly = 2;
  int grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
    req_fun7[7*i +: 7]  = f7;
    req_fun3[3*i +: 3]  = f3;
    req_rs1[32*i +: 32] = a;
    req_rs2[32*i +: 32] = b;
  endtask

  // Called at a negedge; counts negedges until resp_valid[idx] or budget.
  task automatic wait_resp(input int idx, input int budget, output int lat);
    lat = 0;
    while (!resp_valid[idx] && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("resp_valid%0d_seen", idx), {31'd0, resp_valid[idx]}, 32'd1);
  endtask

  task automatic release_resp(input int idx);
    @(posedge clk); #1 resp_ready[idx] = 1'b1;
    @(posedge clk); #1 resp_ready[idx] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (alu_start) starts <= starts + 1;
    if (&req_ready) both_ready <= both_ready + 1;
    if (log_en && |req_ready) grants.push_back(req_ready[1] ? 1 : 0);
  end

  // ALU model: answers done_dly cycles after a start pulse.
  initial begin
    alu_done = 1'b0;
    alu_res  = '0;
    forever begin
      @(posedge clk); #1;
      if (alu_start && alu_en) begin
        repeat (done_dly) @(posedge clk);
        #1;
        alu_res  = (alu_fun7 == FUN7_SUB) ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
        alu_done = 1'b1;
        @(posedge clk); #1 alu_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, s0, n;
    bit stable;
    logic [31:0] r0;
    reset_n = 1'b0; req_valid = '0; resp_ready = '0;
    req_fun7 = '0; req_fun3 = '0; req_rs1 = '0; req_rs2 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_alu_start", {31'd0, alu_start}, 32'd0);
    chk("rst_alu_rs1", alu_rs1, 32'd0);
    chk("rst_resp_res", resp_res, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Single add on requester 0, done two cycles after start
    @(posedge clk); #1;
    set_op(0, 7'h00, ALU_ADDSUB, 32'd5, 32'd7);
    req_valid = 2'b01;
    @(negedge clk); chk("t1_req_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t1_alu_start", {31'd0, alu_start}, 32'd1);
    chk("t1_alu_rs1", alu_rs1, 32'd5);
    chk("t1_alu_rs2", alu_rs2, 32'd7);
    wait_resp(0, 20, lat);
    chk("t1_lat", lat, 32'd3);
    chk("t1_res", resp_res, 32'h0000000C);
    chk("t1_zero", {31'd0, resp_zero}, 32'd0);
    chk("t1_neg", {31'd0, resp_neg}, 32'd0);
    chk("t1_starts", starts, 32'd1);
    release_resp(0);
    @(negedge clk); chk("t1_valid_clr", {30'd0, resp_valid}, 32'd0);

    // Negative subtract on requester 1, done in first WAIT cycle
    done_dly = 1;
    @(posedge clk); #1;
    set_op(1, FUN7_SUB, ALU_ADDSUB, 32'd3, 32'd5);
    req_valid = 2'b10;
    @(negedge clk); chk("t2_req_ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    wait_resp(1, 20, lat);
    chk("t2_lat", lat, 32'd2);
    chk("t2_res", resp_res, 32'hFFFFFFFE);
    chk("t2_neg", {31'd0, resp_neg}, 32'd1);
    chk("t2_zero", {31'd0, resp_zero}, 32'd0);
    release_resp(1);

    // Contention: both valid continuously, four grants
    @(posedge clk); #1;
    set_op(0, 7'h00, ALU_ADDSUB, 32'd10, 32'd20);
    set_op(1, 7'h00, ALU_ADDSUB, 32'd1, 32'd1);
    grants.delete();
    log_en = 1'b1; resp_ready = 2'b11; req_valid = 2'b11;
    n = 0;
    while (grants.size() < 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 req_valid = '0; log_en = 1'b0;
    repeat (8) @(posedge clk);
    #1 resp_ready = '0;
    chk("c_count", grants.size(), 32'd4);
    chk("c_g0", grants[0], 32'd0);
    chk("c_g1", grants[1], 32'd1);
    chk("c_g2", grants[2], 32'd0);
    chk("c_g3", grants[3], 32'd1);
    chk("c_both_ready", both_ready, 32'd0);

    // Backpressure on requester 0 with requester 1 waiting
    set_op(0, 7'h00, ALU_ADDSUB, 32'd100, 32'd1);
    set_op(1, 7'h00, ALU_ADDSUB, 32'd7, 32'd8);
    req_valid = 2'b11;
    @(negedge clk);
    wait_resp(0, 20, lat);
    chk("bp_res", resp_res, 32'h00000065);
    s0 = starts; r0 = resp_res; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 2'b01 || resp_res !== r0 || req_ready !== 2'b00) stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_no_start", starts, s0);
    grants.delete(); log_en = 1'b1;
    @(posedge clk); #1 resp_ready = 2'b01;
    @(posedge clk); #1 resp_ready = 2'b00;
    @(posedge clk); #1 req_valid = '0; log_en = 1'b0;
    chk("bp_next_count", grants.size(), 32'd1);
    chk("bp_next_grant", grants[0], 32'd1);
    resp_ready = 2'b11;
    repeat (8) @(posedge clk);
    #1 resp_ready = '0;

    // Reset during WAIT; the late done must be ignored
    done_dly = 6;
    s0 = starts;
    set_op(0, 7'h00, ALU_ADDSUB, 32'd9, 32'd9);
    req_valid = 2'b01;
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    chk("rw_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rw_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rw_alu_rs1", alu_rs1, 32'd0);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    stable = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 2'b00 || alu_start !== 1'b0) stable = 1'b0;
    end
    chk("rw_late_done_ignored", {31'd0, stable}, 32'd1);
    chk("rw_starts", starts, s0 + 1);
    alu_en = 1'b0;
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk); chk("rw_first_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);

`ifdef ALU_ARB_TIMEOUT_EN
    wait_resp(0, 40, lat);
    chk("to_lat", lat, 32'd17);
    chk("to_res", resp_res, 32'd0);
    chk("to_zero", {31'd0, resp_zero}, 32'd1);
    chk("to_neg", {31'd0, resp_neg}, 32'd0);
    chk("to_err", {31'd0, resp_err}, 32'd1);
    release_resp(0);
    @(negedge clk); chk("to_err_clr", {31'd0, resp_err}, 32'd0);
`else
    repeat (25) @(negedge clk);
    chk("hold_no_valid", {30'd0, resp_valid}, 32'd0);
    chk("hold_no_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single shared `alu` datapath between NUM_REQ requesters, e.g. the execute stage and the branch-compare unit.
- Grants one requester round-robin, latches its operands and fires a one-cycle alu_start.
- Waits for alu_done, then returns the result, zero and neg flags to the granted requester over a valid/ready handshake.
- Sits between the decode/execute logic and the `alu` instance; it is the only driver of the ALU inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- TIMEOUT, 16, WAIT cycles before abort; used only with ALU_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  request accepted (operands latched) this cycle
- req_fun7  in  NUM_REQ*7  fun7 per requester; requester i uses bits [7i+6:7i]
- req_fun3  in  NUM_REQ*3  fun3 per requester
- req_rs1  in  NUM_REQ*32  operand 1 per requester
- req_rs2  in  NUM_REQ*32  operand 2 per requester
- resp_valid  out  NUM_REQ  result valid for requester i
- resp_ready  in  NUM_REQ  requester i consumes the result
- resp_res  out  32  result, shared bus
- resp_zero  out  1  resp_res==0
- resp_neg  out  1  resp_res[31]
- resp_err  out  1  timeout abort; constant 0 without the feature
- alu_start  out  1  one-cycle start pulse to the ALU
- alu_fun7  out  7  latched fun7
- alu_fun3  out  3  latched fun3
- alu_rs1  out  32  latched rs1
- alu_rs2  out  32  latched rs2
- alu_res  in  32  ALU result, valid when alu_done=1
- alu_done  in  1  one-cycle completion pulse from the ALU

Behaviour:
- Reset (async, reset_n=0), all outputs 0:
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins first.
  - Operand and result registers cleared.
  - Reset mid-operation discards the in-flight op. A late alu_done after reset is ignored.
- IDLE:
  - The rr_arbiter picks the first req_valid at or after (last_grant+1) mod NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle only; all other req_ready bits stay 0.
  - Operands are latched to alu_* on that edge; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: alu_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - On alu_done=1, capture alu_res into resp_res.
  - resp_zero=(alu_res==0); resp_neg=alu_res[31] (signed interpretation); go to RESP.
- RESP:
  - resp_valid[g]=1, with resp_res, resp_zero and resp_neg held stable.
  - Hold until resp_ready[g]=1. On that edge: last_grant=g, resp_valid cleared, go to IDLE.
  - resp_ready bits for non-granted requesters are ignored.
- Ordering: at most one operation outstanding.
  - Minimum request-to-resp_valid latency is 3 cycles (accept, ISSUE, WAIT with done in the first WAIT cycle).
  - Minimum back-to-back period is 4 cycles.
- alu_done outside WAIT is ignored; there is no buffering.
- A requester dropping req_valid before its grant is legal; the grant goes to the next valid requester.
- alu_fun7/alu_fun3/alu_rs1/alu_rs2 stay stable from ISSUE until the next grant.
- Fairness: with all requesters valid continuously, grants rotate 0,1,..,NUM_REQ-1,0...

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without alu_done, go to RESP with resp_res=0, resp_zero=1, resp_neg=0, resp_err=1.
  - resp_err clears when RESP exits.
  - alu_done in the same cycle as the counter reaching TIMEOUT wins: normal result, resp_err=0.
- Without the macro: no counter; WAIT holds indefinitely; resp_err tied to 0.

Decomposition:
- Shared constants go in opcode.h: state encoding `ARB_IDLE/`ARB_ISSUE/`ARB_WAIT/`ARB_RESP (2-bit), next to the existing `ALU_* fun3 codes.
- One sub-module, rr_arbiter: combinational round-robin picker.
  - Inputs: req[NUM_REQ], last[log2].
  - Outputs: grant index, any_grant.

Test Plan:
- Single op: requester 0 issues fun3=ADDSUB, fun7=0, rs1=5, rs2=7; ALU done 2 cycles after start -> resp_valid[0] with res=0x0000000C, zero=0, neg=0; exactly one alu_start pulse.
- Sub negative: requester 1 issues fun7=0x20, fun3=ADDSUB, rs1=3, rs2=5 -> res=0xFFFFFFFE, neg=1, zero=0.
- Contention: both requesters valid continuously, four ops -> grant order 0,1,0,1; req_ready is never high for both in the same cycle.
- Backpressure: resp_ready[0] held low for 10 cycles -> resp_valid and resp_res stable; no new alu_start; requester 1 is granted only after the release.
- Reset mid-WAIT: reset_n=0 during WAIT, then alu_done pulses after release -> all outputs 0, state IDLE, no resp_valid.
- Timeout (ALU_ARB_TIMEOUT_EN, TIMEOUT=16): no alu_done -> after 16 WAIT cycles resp_valid with res=0, zero=1, resp_err=1.
